// File: rtl/sh_mem_arbiter_if.sv
// Bus bundle between the shared-memory arbiter and its environment:
// per-core request ports, the VGA fetch port and the memory-array port.
interface sh_mem_arbiter_if #(
   parameter int unsigned NUM_CORES   = 4,
   parameter int unsigned ADDR_SIZE   = 8,
   parameter int unsigned REG_SIZE    = 8,
   parameter int unsigned ENABLE_SIZE = 2
);
   logic [NUM_CORES*ENABLE_SIZE-1:0] enable;
   logic [NUM_CORES*ADDR_SIZE-1:0]   addr;
   logic [NUM_CORES*REG_SIZE-1:0]    wr_data;
   logic [NUM_CORES*REG_SIZE-1:0]    rd_data;
   logic [NUM_CORES-1:0]             ready;
   logic                             vga_req;
   logic [ADDR_SIZE-1:0]             vga_addr;
   logic [REG_SIZE-1:0]              vga_data;
   logic                             vga_valid;
   logic                             mem_en;
   logic                             mem_we;
   logic [ADDR_SIZE-1:0]             mem_addr;
   logic [REG_SIZE-1:0]              mem_wdata;
   logic [REG_SIZE-1:0]              mem_rdata;
   logic                             busy;

   // Environment side: requesters plus the memory array
   modport master (
      output enable, addr, wr_data, vga_req, vga_addr, mem_rdata,
      input  rd_data, ready, vga_data, vga_valid, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   // Arbiter side
   modport slave (
      input  enable, addr, wr_data, vga_req, vga_addr, mem_rdata,
      output rd_data, ready, vga_data, vga_valid, mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/sh_mem_arbiter.sv
// Round-robin arbiter for the single-port shared memory: one access per
// 4-cycle slot, VGA fetches take strict priority over core traffic.
module sh_mem_arbiter #(
   parameter int unsigned NUM_CORES   = 4,
   parameter int unsigned ADDR_SIZE   = 8,
   parameter int unsigned REG_SIZE    = 8,
   parameter int unsigned ENABLE_SIZE = 2
) (
   input logic           clk_i,
   input logic           reset_i,
   sh_mem_arbiter_if.slave bus
);
   localparam int unsigned GID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [ENABLE_SIZE-1:0] EN_RD = ENABLE_SIZE'(1);
   localparam logic [ENABLE_SIZE-1:0] EN_WR = ENABLE_SIZE'(2);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

   state_e                      state_q, state_d;
   logic [GID_W-1:0]            last_grant_q, last_grant_d;
   logic [GID_W-1:0]            grant_id_q, grant_id_d;
   logic                        is_vga_q, is_vga_d;
   logic                        op_we_q, op_we_d;
   logic [NUM_CORES*REG_SIZE-1:0] rd_data_q, rd_data_d;
   logic [NUM_CORES-1:0]        ready_q, ready_d;
   logic [REG_SIZE-1:0]         vga_data_q, vga_data_d;
   logic                        vga_valid_q, vga_valid_d;
   logic                        mem_en_q, mem_en_d;
   logic                        mem_we_q, mem_we_d;
   logic [ADDR_SIZE-1:0]        mem_addr_q, mem_addr_d;
   logic [REG_SIZE-1:0]         mem_wdata_q, mem_wdata_d;
   logic                        busy_q, busy_d;

   logic                        core_found;
   logic [GID_W-1:0]            core_pick;
   logic                        core_we;
   logic [ENABLE_SIZE-1:0]      slot_en;
   int unsigned                 idx;

   // Round-robin search starting just after the last core granted
   always_comb begin
      core_found = 1'b0;
      core_pick  = '0;
      core_we    = 1'b0;
      idx        = 0;
      slot_en    = '0;
      for (int unsigned i = 1; i <= NUM_CORES; i++) begin
         idx     = (32'(last_grant_q) + i) % NUM_CORES;
         slot_en = bus.enable[idx*ENABLE_SIZE +: ENABLE_SIZE];
         if (!core_found && (slot_en == EN_RD || slot_en == EN_WR)) begin
            core_found = 1'b1;
            core_pick  = GID_W'(idx);
            core_we    = (slot_en == EN_WR);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      is_vga_d     = is_vga_q;
      op_we_d      = op_we_q;
      rd_data_d    = rd_data_q;
      vga_data_d   = vga_data_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      ready_d      = '0;
      vga_valid_d  = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Operands go straight into the memory-port registers so they are live in ISSUE
            if (bus.vga_req) begin
               is_vga_d   = 1'b1;
               op_we_d    = 1'b0;
               mem_addr_d = bus.vga_addr;
               mem_en_d   = 1'b1;
               state_d    = ST_ISSUE;
            end else if (core_found) begin
               is_vga_d     = 1'b0;
               grant_id_d   = core_pick;
               last_grant_d = core_pick;
               op_we_d      = core_we;
               mem_addr_d   = bus.addr[32'(core_pick)*ADDR_SIZE +: ADDR_SIZE];
               mem_wdata_d  = bus.wr_data[32'(core_pick)*REG_SIZE +: REG_SIZE];
               mem_we_d     = core_we;
               mem_en_d     = 1'b1;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!op_we_q) begin
               if (is_vga_q) vga_data_d = bus.mem_rdata;
               else          rd_data_d[32'(grant_id_q)*REG_SIZE +: REG_SIZE] = bus.mem_rdata;
            end
            if (is_vga_q) vga_valid_d = 1'b1;
            else          ready_d[grant_id_q] = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GID_W'(NUM_CORES - 1);
         grant_id_q   <= '0;
         is_vga_q     <= 1'b0;
         op_we_q      <= 1'b0;
         rd_data_q    <= '0;
         ready_q      <= '0;
         vga_data_q   <= '0;
         vga_valid_q  <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         is_vga_q     <= is_vga_d;
         op_we_q      <= op_we_d;
         rd_data_q    <= rd_data_d;
         ready_q      <= ready_d;
         vga_data_q   <= vga_data_d;
         vga_valid_q  <= vga_valid_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.ready     = ready_q;
   assign bus.vga_data  = vga_data_q;
   assign bus.vga_valid = vga_valid_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sh_mem_arbiter.sv
// Bench for sh_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model with its own memory image.
module tb_sh_mem_arbiter;
   localparam int unsigned NC = 4;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned EW = 2;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [DW-1:0] mem     [256];
   logic [DW-1:0] ref_mem [256];

   sh_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_SIZE(AW), .REG_SIZE(DW), .ENABLE_SIZE(EW)) bus ();

   sh_mem_arbiter #(.NUM_CORES(NC), .ADDR_SIZE(AW), .REG_SIZE(DW), .ENABLE_SIZE(EW)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory array: read data appears the cycle after the strobe
   always @(posedge clk) begin
      if (bus.mem_en === 1'b1) begin
         bus.mem_rdata <= mem[bus.mem_addr];
         if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic set_core(input int k, input logic [EW-1:0] en, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      bus.enable[k*EW +: EW]  = en;
      bus.addr[k*AW +: AW]    = a;
      bus.wr_data[k*DW +: DW] = d;
   endtask

   task automatic clear_inputs;
      bus.enable   = '0;
      bus.addr     = '0;
      bus.wr_data  = '0;
      bus.vga_req  = 1'b0;
      bus.vga_addr = '0;
   endtask

   task automatic preload;
      logic [DW-1:0] v;
      for (int i = 0; i < 256; i++) begin
         v = (i == 32) ? 8'h3C : DW'($urandom);
         mem[i]     = v;
         ref_mem[i] = v;
      end
   endtask

   // Leaves the bench at a negedge with reset just released and the FSM idle
   task automatic do_reset;
      tick;
      reset = 1'b1;
      clear_inputs;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      tick;
      reset = 1'b1;
      clear_inputs;
      tick;
      tick;
      total++;
      if ({bus.busy, bus.mem_en, bus.mem_we, bus.ready, bus.vga_valid} !== '0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=0", {bus.busy, bus.mem_en, bus.mem_we, bus.ready, bus.vga_valid});
      end
      total++;
      if ({bus.mem_addr, bus.mem_wdata, bus.rd_data, bus.vga_data} !== '0) begin
         bad++;
         $display("FAIL reset_data got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.rd_data, bus.vga_data});
      end
      reset = 1'b0;
   endtask

   task automatic test_single_read;
      do_reset;
      set_core(2, 2'b10, 8'h10, 8'hA5);
      tick;
      total++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 8'h10, 8'hA5}) begin
         bad++;
         $display("FAIL sr_write_issue got=%h exp=%h", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                  {1'b1, 1'b1, 8'h10, 8'hA5});
      end
      tick;
      tick;
      total++;
      if (bus.ready !== 4'b0100) begin
         bad++;
         $display("FAIL sr_write_ready got=%b exp=0100", bus.ready);
      end
      set_core(2, 2'b00, 8'h00, 8'h00);
      tick;
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL sr_idle_busy got=%b exp=0", bus.busy);
      end
      set_core(2, 2'b01, 8'h10, 8'h00);
      tick;
      total++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
         bad++;
         $display("FAIL sr_read_issue got=%h exp=%h", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h10});
      end
      tick;
      tick;
      total++;
      if (bus.ready !== 4'b0100) begin
         bad++;
         $display("FAIL sr_read_ready got=%b exp=0100", bus.ready);
      end
      total++;
      if (bus.rd_data !== 32'h00A5_0000) begin
         bad++;
         $display("FAIL sr_rd_data got=%h exp=00a50000", bus.rd_data);
      end
      set_core(2, 2'b00, 8'h00, 8'h00);
      tick;
   endtask

   task automatic test_round_robin;
      logic [NC-1:0] er;
      do_reset;
      for (int k = 0; k < NC; k++) set_core(k, 2'b01, AW'(8'h60 + k), 8'h00);
      for (int c = 1; c <= 20; c++) begin
         tick;
         er = '0;
         if (c % 4 == 3) er[(c / 4) % 4] = 1'b1;
         total++;
         if (bus.ready !== er) begin
            bad++;
            $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, bus.ready, er);
         end
      end
      clear_inputs;
   endtask

   task automatic test_vga_priority;
      do_reset;
      bus.vga_req  = 1'b1;
      bus.vga_addr = 8'h20;
      set_core(1, 2'b01, 8'h30, 8'h00);
      set_core(3, 2'b01, 8'h31, 8'h00);
      tick;
      total++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h20}) begin
         bad++;
         $display("FAIL vga_issue got=%h exp=%h", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h20});
      end
      tick;
      tick;
      total++;
      if ({bus.vga_valid, bus.ready, bus.vga_data} !== {1'b1, 4'b0000, 8'h3C}) begin
         bad++;
         $display("FAIL vga_done got=%h exp=%h", {bus.vga_valid, bus.ready, bus.vga_data}, {1'b1, 4'b0000, 8'h3C});
      end
      bus.vga_req = 1'b0;
      repeat (4) tick;
      total++;
      if ({bus.ready, bus.rd_data[15:8]} !== {4'b0010, ref_mem[8'h30]}) begin
         bad++;
         $display("FAIL vga_next_core1 got=%h exp=%h", {bus.ready, bus.rd_data[15:8]}, {4'b0010, ref_mem[8'h30]});
      end
      set_core(1, 2'b00, 8'h00, 8'h00);
      repeat (4) tick;
      total++;
      if ({bus.ready, bus.rd_data[31:24]} !== {4'b1000, ref_mem[8'h31]}) begin
         bad++;
         $display("FAIL vga_then_core3 got=%h exp=%h", {bus.ready, bus.rd_data[31:24]}, {4'b1000, ref_mem[8'h31]});
      end
      clear_inputs;
   endtask

   task automatic test_invalid_enable;
      do_reset;
      set_core(0, 2'b11, 8'h05, 8'h77);
      for (int c = 1; c <= 20; c++) begin
         tick;
         total++;
         if ({bus.busy, bus.mem_en, bus.ready} !== '0) begin
            bad++;
            $display("FAIL inv_en_idle cyc=%0d got=%b exp=0", c, {bus.busy, bus.mem_en, bus.ready});
         end
      end
      clear_inputs;
   endtask

   task automatic test_reset_mid_access;
      logic [NC-1:0] er;
      do_reset;
      set_core(1, 2'b01, 8'h40, 8'h00);
      tick;
      tick;
      reset = 1'b1;
      tick;
      total++;
      if ({bus.busy, bus.mem_en, bus.mem_we, bus.ready, bus.vga_valid, bus.mem_addr, bus.mem_wdata,
           bus.rd_data, bus.vga_data} !== '0) begin
         bad++;
         $display("FAIL rst_mid_outputs got=%h exp=0", {bus.busy, bus.mem_en, bus.mem_we, bus.ready,
                  bus.vga_valid, bus.mem_addr, bus.mem_wdata, bus.rd_data, bus.vga_data});
      end
      reset = 1'b0;
      set_core(0, 2'b01, 8'h41, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         tick;
         er = (c == 3) ? 4'b0001 : (c == 7) ? 4'b0010 : 4'b0000;
         total++;
         if (bus.ready !== er) begin
            bad++;
            $display("FAIL rst_mid_order cyc=%0d got=%b exp=%b", c, bus.ready, er);
         end
         if (c == 3) set_core(0, 2'b00, 8'h00, 8'h00);
         if (c == 7) set_core(1, 2'b00, 8'h00, 8'h00);
      end
   endtask

   task automatic test_back_to_back;
      logic [NC-1:0] er;
      logic          ee;
      do_reset;
      set_core(3, 2'b01, 8'h50, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         tick;
         er = (c == 3 || c == 7) ? 4'b1000 : 4'b0000;
         ee = (c == 1 || c == 5);
         total++;
         if ({bus.ready, bus.mem_en} !== {er, ee}) begin
            bad++;
            $display("FAIL b2b cyc=%0d got=%b exp=%b", c, {bus.ready, bus.mem_en}, {er, ee});
         end
         if (c == 7) set_core(3, 2'b00, 8'h00, 8'h00);
      end
   endtask

   task automatic test_random;
      logic [EW-1:0]    m_en   [NC];
      logic [AW-1:0]    m_addr [NC];
      logic [DW-1:0]    m_wd   [NC];
      bit               pend   [NC];
      bit               vpend;
      logic [AW-1:0]    vaddr;
      int               last, g_t, g_who, next_arb, ph, k, r;
      bit               g_we, found;
      logic [AW-1:0]    g_addr;
      logic [DW-1:0]    g_wd, g_rdata, m_vd;
      logic [NC*DW-1:0] m_rd;
      logic [NC-1:0]    er;
      preload;
      do_reset;
      for (int i = 0; i < NC; i++) begin
         m_en[i] = '0; m_addr[i] = '0; m_wd[i] = '0; pend[i] = 1'b0;
      end
      vpend = 1'b0; vaddr = '0; last = NC - 1; g_t = -100; g_who = 0; next_arb = 0;
      g_we = 1'b0; g_addr = '0; g_wd = '0; g_rdata = '0; m_vd = '0; m_rd = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc > 0) tick;
         ph = cyc - g_t;
         if (ph == 3 && !g_we) begin
            if (g_who < 0) m_vd = g_rdata;
            else           m_rd[g_who*DW +: DW] = g_rdata;
         end
         er = '0;
         if (ph == 3 && g_who >= 0) er[g_who] = 1'b1;
         total++;
         if ({bus.busy, bus.mem_en, bus.ready, bus.vga_valid} !==
             {(ph >= 1 && ph <= 3), (ph == 1), er, (ph == 3 && g_who < 0)}) begin
            bad++;
            $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {bus.busy, bus.mem_en, bus.ready, bus.vga_valid},
                     {(ph >= 1 && ph <= 3), (ph == 1), er, (ph == 3 && g_who < 0)});
         end
         total++;
         if ({bus.rd_data, bus.vga_data} !== {m_rd, m_vd}) begin
            bad++;
            $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, {bus.rd_data, bus.vga_data}, {m_rd, m_vd});
         end
         if (ph == 1) begin
            total++;
            if ({bus.mem_we, bus.mem_addr} !== {g_we, g_addr} || (g_we && bus.mem_wdata !== g_wd)) begin
               bad++;
               $display("FAIL rnd_issue cyc=%0d got=%h exp=%h", cyc, {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                        {g_we, g_addr, g_wd});
            end
         end
         // Requester side: release on completion, new requests, operand churn after grant
         if (ph == 3) begin
            if (g_who < 0) vpend = 1'b0;
            else begin pend[g_who] = 1'b0; m_en[g_who] = '0; end
         end
         if ((ph == 1 || ph == 2) && g_who >= 0 && ($urandom % 2) == 0) begin
            m_addr[g_who] = AW'($urandom);
            m_wd[g_who]   = DW'($urandom);
         end
         for (int i = 0; i < NC; i++) begin
            if (!pend[i] && ($urandom % 4) == 0) begin
               r         = int'($urandom % 4);
               m_en[i]   = EW'(r);
               m_addr[i] = AW'($urandom);
               m_wd[i]   = DW'($urandom);
               pend[i]   = (r == 1 || r == 2);
            end
         end
         if (!vpend && ($urandom % 16) == 0) begin
            vpend = 1'b1;
            vaddr = AW'($urandom);
         end
         for (int i = 0; i < NC; i++) set_core(i, m_en[i], m_addr[i], m_wd[i]);
         bus.vga_req  = vpend;
         bus.vga_addr = vaddr;
         if (cyc == next_arb) begin
            next_arb = cyc + 1;
            if (vpend) begin
               g_who = -1; g_we = 1'b0; g_addr = vaddr; g_rdata = ref_mem[vaddr];
               g_t = cyc; next_arb = cyc + 4;
            end else begin
               found = 1'b0;
               for (int j = 1; j <= NC; j++) begin
                  k = (last + j) % NC;
                  if (!found && pend[k]) begin
                     found = 1'b1;
                     g_who = k; g_we = (m_en[k] == 2'b10); g_addr = m_addr[k]; g_wd = m_wd[k];
                     if (g_we) ref_mem[g_addr] = g_wd;
                     else      g_rdata = ref_mem[g_addr];
                     last = k; g_t = cyc; next_arb = cyc + 4;
                  end
               end
            end
         end
      end
      clear_inputs;
      repeat (5) tick;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      clear_inputs;
      preload;
      test_reset;
      test_single_read;
      test_round_robin;
      test_vga_priority;
      test_invalid_enable;
      test_reset_mid_access;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
